uart_tx_sequencer: RTL and testbench
====================================

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16, meaning the number of result words per frame (power of two, >=2).
REQ-002 SHALL have parameter WORD_BYTES, default 4, meaning bytes per word (16-bit real in [15:0], 16-bit imag in [31:16]).
REQ-003 SHALL have parameter HEADER_BYTE, default 8'hA5, meaning the first byte of every frame.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  single clock; all logic on the rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  one-cycle request to send one frame.
REQ-008 o_busy  out  1  high from the cycle after i_start is accepted until o_frame_done.
REQ-009 o_frame_done  out  1  one-cycle pulse after the last byte's i_tx_done.
REQ-010 o_rd_en, o_rd_addr  out  1, log2(NUM_WORDS)  result-buffer read; i_rd_data is valid exactly 1 cycle after o_rd_en.
REQ-011 i_rd_data  in  8*WORD_BYTES  result-buffer read data.
REQ-012 o_tx_start, o_tx_byte  out  1, 8  byte request to the UART transmitter.
REQ-013 i_tx_busy, i_tx_done  in  1, 1  transmitter transfer-state level and one-cycle done pulse.

Function
REQ-014 SHALL implement states IDLE, HDR, RD, LATCH, ISSUE, WAIT, NEXT, DONE.
REQ-015 IDLE: i_start=1 -> HDR, with the word address and byte index cleared; otherwise stay.
REQ-016 ISSUE/HDR SHALL assert o_tx_start for exactly one cycle, only when i_tx_busy=0; if busy, hold state with o_tx_start=0.
REQ-017 o_tx_byte SHALL be set in the same cycle as o_tx_start and held stable until i_tx_done.
REQ-018 WAIT SHALL hold until i_tx_done=1; i_tx_done in any other state SHALL be ignored.
REQ-019 Byte order: header, then words 0..NUM_WORDS-1, each little-endian (byte 0 = i_rd_data[7:0]).
REQ-020 RD SHALL pulse o_rd_en with o_rd_addr = the word index; LATCH SHALL capture i_rd_data into an internal word register one cycle later.
REQ-021 NEXT: byte index < WORD_BYTES-1 -> increment, ISSUE; else word index < NUM_WORDS-1 -> increment word, clear byte index, RD; else DONE.
REQ-022 DONE SHALL pulse o_frame_done for 1 cycle, then go to IDLE; o_busy drops in the same cycle.
REQ-023 i_start while o_busy=1 SHALL be ignored (not queued).
REQ-024 A frame is 1+NUM_WORDS*WORD_BYTES bytes (65 by default) without the checksum option.
REQ-025 The word index SHALL never wrap; at most one read per word.

Reset
REQ-026 On i_rst: state=IDLE; o_busy, o_frame_done, o_rd_en, o_tx_start = 0; o_tx_byte = 8'h00; o_rd_addr = 0; indices and checksum cleared.
REQ-027 i_rst mid-frame SHALL abort immediately, with no further o_tx_start; an in-flight transmitter byte completes externally and its i_tx_done is ignored.

Configuration
REQ-028 Macro UART_TX_SEQ_CHECKSUM_EN defined: an extra state CHK sends the XOR of all data bytes (header excluded) after the last data byte, before DONE; frame = 66 bytes by default.
REQ-029 Macro undefined: no CHK state, no checksum register; DONE follows the last data byte.

Structure
REQ-030 Package uart_tx_seq_pkg SHALL hold the state encoding constants and the default HEADER_BYTE.
REQ-031 Sub-module uart_tx_seq_byte_sel SHALL be the combinational selection of byte k from the word register; everything else stays in the top.

Verification
REQ-032 Buffer word n = {n+16'h100, n} (16-bit halves), i_start pulse, transmitter model done after 20 cycles -> bytes A5, 00,00,00,01, 01,00,01,01, ..., 0F,00,0F,01; o_frame_done once; o_tx_start count = 65.
REQ-033 Hold i_tx_busy=1 for 50 cycles at frame start -> no o_tx_start until busy falls, then header A5.
REQ-034 i_start re-pulsed at byte 10 -> ignored; exactly one frame sent; a second i_start after o_frame_done sends a full second frame.
REQ-035 i_rst at byte 30 -> all outputs at reset values next cycle; a spurious i_tx_done afterwards produces no activity; a new i_start sends the full frame from A5.
REQ-036 With UART_TX_SEQ_CHECKSUM_EN and the REQ-032 data -> a 66th byte equal to the XOR of the 64 data bytes (8'h00 for that pattern; a second pattern with word 0 = 32'h000000FF gives 8'hFF).
REQ-037 The bench SHALL check o_tx_byte stable from o_tx_start to i_tx_done and o_rd_en exactly once per word.

Source files
------------

// File: rtl/uart_tx_seq_pkg.sv
// Shared definitions for the UART TX frame sequencer.
// Holds the FSM state encoding, the byte-kind tag used to pick the successor of StWait,
// and the default frame header byte.
// Optional feature macro: UART_TX_SEQ_CHECKSUM_EN adds the StChk state.
package uart_tx_seq_pkg;

    localparam logic [7:0] DefaultHeaderByte = 8'hA5;

    typedef enum logic [3:0] {
        StIdle  = 4'd0,
        StHdr   = 4'd1,
        StRd    = 4'd2,
        StLatch = 4'd3,
        StIssue = 4'd4,
        StWait  = 4'd5,
        StNext  = 4'd6,
        StDone  = 4'd7
`ifdef UART_TX_SEQ_CHECKSUM_EN
        , StChk = 4'd8
`endif
    } seq_state_e;

    // What the byte currently in flight was, so StWait knows where to go next.
    typedef enum logic [1:0] {
        KindHdr  = 2'd0,
        KindData = 2'd1,
        KindChk  = 2'd2
    } byte_kind_e;

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Result-buffer read port and UART transmitter byte port of the frame sequencer.
// Signals:
//   o_rd_en, o_rd_addr : buffer read request (sequencer -> buffer)
//   i_rd_data          : buffer read data, valid one cycle after o_rd_en
//   o_tx_start, o_tx_byte : byte request (sequencer -> transmitter)
//   i_tx_busy, i_tx_done  : transmitter state level and one-cycle done pulse
// Modports: master = sequencer side, slave = buffer/transmitter side.
interface uart_tx_sequencer_if #(
    parameter int unsigned NUM_WORDS  = 16,
    parameter int unsigned WORD_BYTES = 4
);
    localparam int unsigned AddrW = $clog2(NUM_WORDS);

    logic                    o_rd_en;
    logic [AddrW-1:0]        o_rd_addr;
    logic [8*WORD_BYTES-1:0] i_rd_data;
    logic                    o_tx_start;
    logic [7:0]              o_tx_byte;
    logic                    i_tx_busy;
    logic                    i_tx_done;

    modport master (
        output o_rd_en, o_rd_addr, o_tx_start, o_tx_byte,
        input  i_rd_data, i_tx_busy, i_tx_done
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_tx_start, o_tx_byte,
        output i_rd_data, i_tx_busy, i_tx_done
    );
endinterface

// File: rtl/uart_tx_seq_byte_sel.sv
// Combinational selection of byte k (little-endian) from the latched result word.
// Ports:
//   word_i     : latched word, 8*WORD_BYTES bits
//   byte_idx_i : byte index within the word
//   byte_o     : selected byte (word_i[8k+7:8k])
module uart_tx_seq_byte_sel #(
    parameter int unsigned WORD_BYTES = 4,
    localparam int unsigned ByteW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic [8*WORD_BYTES-1:0] word_i,
    input  logic [ByteW-1:0]        byte_idx_i,
    output logic [7:0]              byte_o
);

    always_comb begin
        byte_o = 8'h00;
        for (int k = 0; k < int'(WORD_BYTES); k++) begin
            if (byte_idx_i == ByteW'(k)) begin
                byte_o = word_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART TX frame sequencer: on i_start sends HEADER_BYTE followed by NUM_WORDS result words,
// each WORD_BYTES bytes little-endian, one byte per transmitter handshake.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : one-cycle frame request (ignored while a frame is in progress)
//   o_busy            : frame in progress
//   o_frame_done      : one-cycle pulse once the last byte has completed
//   bus_io            : buffer read port and transmitter byte port (master modport)
// Optional feature macro: UART_TX_SEQ_CHECKSUM_EN appends the XOR of all data bytes
// (header excluded) as a final byte.
module uart_tx_sequencer
    import uart_tx_seq_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WORD_BYTES  = 4,
    parameter logic [7:0]  HEADER_BYTE = DefaultHeaderByte
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_frame_done,
    uart_tx_sequencer_if.master  bus_io
);

    localparam int unsigned AddrW = $clog2(NUM_WORDS);
    localparam int unsigned ByteW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned WordW = 8 * WORD_BYTES;

    localparam logic [AddrW-1:0] LastWord = AddrW'(NUM_WORDS - 1);
    localparam logic [ByteW-1:0] LastByte = ByteW'(WORD_BYTES - 1);

    seq_state_e       state_q;
    byte_kind_e       kind_q;
    logic [AddrW-1:0] word_idx_q;
    logic [ByteW-1:0] byte_idx_q;
    logic [WordW-1:0] word_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             rd_en_q;
    logic [AddrW-1:0] rd_addr_q;
    logic             tx_start_q;
    logic [7:0]       tx_byte_q;
`ifdef UART_TX_SEQ_CHECKSUM_EN
    logic [7:0]       chk_q;
`endif

    logic [7:0] sel_byte;

    uart_tx_seq_byte_sel #(
        .WORD_BYTES (WORD_BYTES)
    ) u_byte_sel (
        .word_i     (word_q),
        .byte_idx_i (byte_idx_q),
        .byte_o     (sel_byte)
    );

    // Outputs are registered and raised on the transition into the state they belong to,
    // so o_rd_en is high during StRd and the read data is valid during StLatch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            kind_q       <= KindHdr;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
`ifdef UART_TX_SEQ_CHECKSUM_EN
            chk_q        <= 8'h00;
`endif
        end else begin
            tx_start_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        busy_q     <= 1'b1;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
                        chk_q      <= 8'h00;
`endif
                        state_q    <= StHdr;
                    end
                end

                StHdr: begin
                    if (!bus_io.i_tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= HEADER_BYTE;
                        kind_q     <= KindHdr;
                        state_q    <= StWait;
                    end
                end

                StRd: begin
                    state_q <= StLatch;
                end

                StLatch: begin
                    word_q  <= bus_io.i_rd_data;
                    state_q <= StIssue;
                end

                StIssue: begin
                    if (!bus_io.i_tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= sel_byte;
`ifdef UART_TX_SEQ_CHECKSUM_EN
                        chk_q      <= chk_q ^ sel_byte;
`endif
                        kind_q     <= KindData;
                        state_q    <= StWait;
                    end
                end

                StWait: begin
                    if (bus_io.i_tx_done) begin
                        case (kind_q)
                            KindHdr: begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= word_idx_q;
                                state_q   <= StRd;
                            end
                            KindData: begin
                                state_q <= StNext;
                            end
                            default: begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                state_q      <= StDone;
                            end
                        endcase
                    end
                end

                StNext: begin
                    if (byte_idx_q != LastByte) begin
                        byte_idx_q <= byte_idx_q + ByteW'(1);
                        state_q    <= StIssue;
                    end else if (word_idx_q != LastWord) begin
                        word_idx_q <= word_idx_q + AddrW'(1);
                        byte_idx_q <= '0;
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= word_idx_q + AddrW'(1);
                        state_q    <= StRd;
                    end else begin
`ifdef UART_TX_SEQ_CHECKSUM_EN
                        state_q      <= StChk;
`else
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= StDone;
`endif
                    end
                end

`ifdef UART_TX_SEQ_CHECKSUM_EN
                StChk: begin
                    if (!bus_io.i_tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_byte_q  <= chk_q;
                        kind_q     <= KindChk;
                        state_q    <= StWait;
                    end
                end
`endif

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_busy            = busy_q;
    assign o_frame_done      = frame_done_q;
    assign bus_io.o_rd_en    = rd_en_q;
    assign bus_io.o_rd_addr  = rd_addr_q;
    assign bus_io.o_tx_start = tx_start_q;
    assign bus_io.o_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer: buffer and transmitter models, scoreboard of expected
// bytes filled when a frame is requested and drained as bytes are issued.
module tb_uart_tx_sequencer;

    localparam int unsigned NumWords  = 16;
    localparam int unsigned WordBytes = 4;
    localparam int unsigned TxCycles  = 20;
`ifdef UART_TX_SEQ_CHECKSUM_EN
    localparam int unsigned FrameLen  = 1 + NumWords * WordBytes + 1;
`else
    localparam int unsigned FrameLen  = 1 + NumWords * WordBytes;
`endif

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;

    uart_tx_sequencer_if #(
        .NUM_WORDS  (NumWords),
        .WORD_BYTES (WordBytes)
    ) bus ();

    uart_tx_sequencer #(
        .NUM_WORDS   (NumWords),
        .WORD_BYTES  (WordBytes),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .bus_io       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [NumWords];
    logic [31:0] exp_q [$];

    // Monitor / model state
    int         bytes_sent = 0;
    int         done_cnt   = 0;
    int         rd_total   = 0;
    int         rd_cnt [NumWords];
    logic       hold_busy  = 1'b0;
    logic       mdl_active = 1'b0;
    int         mdl_cnt    = 0;
    logic [7:0] cur_byte   = 8'h00;
    logic       track      = 1'b0;
    logic       rd_pend    = 1'b0;
    logic [3:0] pend_addr  = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model, buffer model and per-cycle monitors, all on the falling edge.
    initial begin
        bus.i_tx_busy = 1'b0;
        bus.i_tx_done = 1'b0;
        bus.i_rd_data = 32'h0;
        forever begin
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            if (rst) track = 1'b0;
            if (mdl_active) begin
                if (track) check("tx_byte_stable", {24'h0, bus.o_tx_byte}, {24'h0, cur_byte});
                check("tx_start_while_tx_busy", {31'h0, bus.o_tx_start}, 32'h0);
                mdl_cnt++;
                if (mdl_cnt == int'(TxCycles)) begin
                    bus.i_tx_done = 1'b1;
                    mdl_active    = 1'b0;
                end
            end else if (bus.o_tx_start === 1'b1) begin
                logic [31:0] exp;
                mdl_active = 1'b1;
                mdl_cnt    = 0;
                cur_byte   = bus.o_tx_byte;
                track      = 1'b1;
                bytes_sent++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h100;
                check("tx_byte", {24'h0, bus.o_tx_byte}, exp);
            end
            bus.i_tx_busy = mdl_active | hold_busy;

            // Read data is valid only in the cycle after the request.
            if (rd_pend) bus.i_rd_data = mem[pend_addr];
            else         bus.i_rd_data = 32'hDEAD_BEEF;
            rd_pend   = (bus.o_rd_en === 1'b1);
            pend_addr = bus.o_rd_addr;
            if (bus.o_rd_en === 1'b1) begin
                rd_total++;
                rd_cnt[bus.o_rd_addr]++;
            end
            if (frame_done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int n = 0; n < int'(NumWords); n++) begin
            if (pat == 0) mem[n] = ((32'(n) + 32'h100) << 16) | 32'(n);
            else          mem[n] = (n == 0) ? 32'h0000_00FF : 32'h0;
        end
    endtask

    task automatic push_frame();
        logic [7:0] chk;
        logic [7:0] b;
        chk = 8'h00;
        exp_q.push_back(32'hA5);
        for (int w = 0; w < int'(NumWords); w++) begin
            for (int k = 0; k < int'(WordBytes); k++) begin
                b = mem[w][8*k +: 8];
                exp_q.push_back({24'h0, b});
                chk = chk ^ b;
            end
        end
`ifdef UART_TX_SEQ_CHECKSUM_EN
        exp_q.push_back({24'h0, chk});
`endif
    endtask

    task automatic begin_frame();
        bytes_sent = 0;
        done_cnt   = 0;
        rd_total   = 0;
        for (int i = 0; i < int'(NumWords); i++) rd_cnt[i] = 0;
        push_frame();
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("busy_after_start", {31'h0, busy}, 32'h1);
    endtask

    task automatic finish_frame(input string tag);
        logic got;
        int   bad;
        got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            if (frame_done === 1'b1) begin
                got = 1'b1;
                check("busy_low_with_done", {31'h0, busy}, 32'h0);
                break;
            end
        end
        check({tag, "_frame_done_seen"}, {31'h0, got}, 32'h1);
        step(3);
        bad = 0;
        for (int i = 0; i < int'(NumWords); i++) if (rd_cnt[i] != 1) bad++;
        check({tag, "_byte_count"}, bytes_sent, FrameLen);
        check({tag, "_scoreboard_empty"}, exp_q.size(), 0);
        check({tag, "_frame_done_count"}, done_cnt, 1);
        check({tag, "_rd_total"}, rd_total, NumWords);
        check({tag, "_rd_words_not_once"}, bad, 0);
    endtask

    task automatic wait_bytes(input int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (bytes_sent >= n) begin
                got = 1'b1;
                break;
            end
            step(1);
        end
        check("reached_byte_target", {31'h0, got}, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
        check({tag, "_rd_en"}, {31'h0, bus.o_rd_en}, 32'h0);
        check({tag, "_rd_addr"}, {28'h0, bus.o_rd_addr}, 32'h0);
        check({tag, "_tx_start"}, {31'h0, bus.o_tx_start}, 32'h0);
        check({tag, "_tx_byte"}, {24'h0, bus.o_tx_byte}, 32'h0);
    endtask

    initial begin
        int saved_bytes;
        int saved_rd;
        rst   = 1'b1;
        start = 1'b0;
        load_pattern(0);
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(2);

        // Basic frame with the counting pattern.
        begin_frame();
        finish_frame("basic");

        // Transmitter busy at frame start: nothing may be issued until it frees up.
        hold_busy = 1'b1;
        begin_frame();
        step(50);
        check("held_busy_no_tx_start", bytes_sent, 0);
        check("held_busy_still_busy", {31'h0, busy}, 32'h1);
        hold_busy = 1'b0;
        finish_frame("held_busy");

        // Start re-pulsed mid-frame is ignored; later start gives a second full frame.
        begin_frame();
        wait_bytes(10);
        start = 1'b1;
        step(1);
        start = 1'b0;
        finish_frame("restart_ignored");
        step(40);
        check("no_queued_frame_bytes", bytes_sent, FrameLen);
        check("no_queued_frame_busy", {31'h0, busy}, 32'h0);
        begin_frame();
        finish_frame("second_frame");

        // Reset mid-frame: abort, ignore the trailing tx_done, then restart cleanly.
        begin_frame();
        wait_bytes(30);
        rst = 1'b1;
        step(1);
        check_reset_outputs("abort");
        rst = 1'b0;
        exp_q.delete();
        saved_bytes = bytes_sent;
        saved_rd    = rd_total;
        step(40);
        check("abort_no_tx_start", bytes_sent, saved_bytes);
        check("abort_no_rd_en", rd_total, saved_rd);
        check("abort_no_frame_done", done_cnt, 0);
        check("abort_idle_busy", {31'h0, busy}, 32'h0);
        begin_frame();
        finish_frame("after_abort");

        // Second data pattern (word 0 = 0x000000FF, others zero).
        load_pattern(1);
        step(2);
        begin_frame();
        finish_frame("pattern_ff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
